// File: rtl/edge_pkg.sv
// Shared types and helpers for the hysteresis edge tracker.
package edge_pkg;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_WEAK   = 2'd1,
    CLS_STRONG = 2'd2
  } cls_e;

  typedef enum logic [1:0] {
    BUF_SRC   = 2'd0,
    BUF_SCR_A = 2'd1,
    BUF_SCR_B = 2'd2,
    BUF_DST   = 2'd3
  } buf_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_EVAL,
    ST_OUT_SCAN,
    ST_OUT_DRAIN
  } trk_state_e;

  localparam int ABS_W = 32;

  // Wide enough that the most negative pixel word has an exact magnitude.
  function automatic logic abs_gt(input logic signed [ABS_W-1:0] v, input logic [ABS_W-1:0] t);
    logic [ABS_W-1:0] mag;
    mag = v[ABS_W-1] ? unsigned'(-v) : unsigned'(v);
    return mag > t;
  endfunction

endpackage

// File: rtl/edge_trk_rd_pipe.sv
// Delay line carrying read-request valid and centre coordinate until the window data returns.
module edge_trk_rd_pipe #(
  parameter int RD_LAT     = 1,
  parameter int COORD_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_vld,
  input  logic [COORD_BITS-1:0] in_x,
  input  logic [COORD_BITS-1:0] in_y,
  output logic                  out_vld,
  output logic [COORD_BITS-1:0] out_x,
  output logic [COORD_BITS-1:0] out_y
);

  logic [RD_LAT-1:0]     vld;
  logic [COORD_BITS-1:0] xs [RD_LAT];
  logic [COORD_BITS-1:0] ys [RD_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      vld <= '0;
    end else begin
      vld[0] <= in_vld;
      for (int i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
      end
    end else begin
      xs[0] <= in_x;
      ys[0] <= in_y;
      for (int i = 1; i < RD_LAT; i++) begin
        xs[i] <= xs[i-1];
        ys[i] <= ys[i-1];
      end
    end
  end

  assign out_vld = vld[RD_LAT-1];
  assign out_x   = xs[RD_LAT-1];
  assign out_y   = ys[RD_LAT-1];

endmodule

// File: rtl/edge_trk_iter.sv
// Multi-pass hysteresis edge tracker: classify, promote weak pixels touching strong ones, emit edge map.
// state     | meaning
// IDLE      | waiting for start
// SCAN      | raster window reads of a classify/promote pass
// DRAIN     | letting the pass's in-flight writes land
// EVAL      | choose another promote pass or the output pass
// OUT_SCAN  | raster window reads of the output pass
// OUT_DRAIN | waiting for the last DST write, then pulse done
module edge_trk_iter
  import edge_pkg::*;
#(
  parameter int IMG_WD     = 640,
  parameter int IMG_HT     = 480,
  parameter int COORD_BITS = 10,
  parameter int WIN_WD     = 3,
  parameter int WIN_HT     = 3,
  parameter int PXL_BITS   = 12,
  parameter int RD_LAT     = 1,
  parameter int MAX_PASSES = 8,
  parameter int PASS_BITS  = 4,
  parameter int EDGE_VAL   = 2047
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic [PXL_BITS-1:0]                 thresh_hi,
  input  logic [PXL_BITS-1:0]                 thresh_lo,
  output logic                                busy,
  output logic                                done,
  output logic                                converged,
  output logic [PASS_BITS-1:0]                pass_cnt,
  output logic [$clog2(IMG_WD*IMG_HT+1)-1:0]  promo_cnt,
  output logic                                rd_en,
  output logic [COORD_BITS-1:0]               rd_x,
  output logic [COORD_BITS-1:0]               rd_y,
  output logic [1:0]                          rd_sel,
  input  logic [WIN_HT*WIN_WD*PXL_BITS-1:0]   rd_data_flat,
  output logic                                wr_en,
  output logic [COORD_BITS-1:0]               wr_x,
  output logic [COORD_BITS-1:0]               wr_y,
  output logic [1:0]                          wr_sel,
  output logic [PXL_BITS-1:0]                 wr_data_pxl
);

  localparam int NTAP       = WIN_WD * WIN_HT;
  localparam int CEN        = (WIN_HT / 2) * WIN_WD + WIN_WD / 2;
  localparam int PROMO_BITS = $clog2(IMG_WD * IMG_HT + 1);
  localparam int DRN_BITS   = $clog2(RD_LAT + 1);
  localparam logic [COORD_BITS-1:0] X_LAST = COORD_BITS'(IMG_WD - 1);
  localparam logic [COORD_BITS-1:0] Y_LAST = COORD_BITS'(IMG_HT - 1);

  trk_state_e            state;
  logic [PXL_BITS-1:0]   hi_q, lo_q;
  logic [DRN_BITS-1:0]   drn_cnt;
  logic [PASS_BITS-1:0]  pass_nxt;
  logic                  kill;
  logic                  p_vld;
  logic [COORD_BITS-1:0] p_x, p_y;

  logic [PXL_BITS-1:0]   tap [NTAP];
  logic                  any_hi, any_strong;
  logic [1:0]            res_cls;
  logic                  res_promo;
  logic [PXL_BITS-1:0]   res_word;

  assign kill     = abort && (state != ST_IDLE);
  assign pass_nxt = pass_cnt + 1'b1;

  edge_trk_rd_pipe #(
    .RD_LAT    (RD_LAT),
    .COORD_BITS(COORD_BITS)
  ) u_rd_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (kill),
    .in_vld (rd_en),
    .in_x   (rd_x),
    .in_y   (rd_y),
    .out_vld(p_vld),
    .out_x  (p_x),
    .out_y  (p_y)
  );

  always_comb begin
    any_hi     = 1'b0;
    any_strong = 1'b0;
    for (int i = 0; i < NTAP; i++) begin
      tap[i] = rd_data_flat[i*PXL_BITS +: PXL_BITS];
      if (abs_gt(ABS_W'(signed'(tap[i])), ABS_W'(hi_q))) any_hi = 1'b1;
      if (tap[i][1:0] == CLS_STRONG) any_strong = 1'b1;
    end
  end

  // Pass 0 classifies raw gradients; later passes read class words back from scratch.
  always_comb begin
    res_cls   = CLS_NONE;
    res_promo = 1'b0;
    if (rd_sel == BUF_SRC) begin
      if (abs_gt(ABS_W'(signed'(tap[CEN])), ABS_W'(hi_q))) begin
        res_cls = CLS_STRONG;
      end else if (abs_gt(ABS_W'(signed'(tap[CEN])), ABS_W'(lo_q))) begin
        res_cls   = any_hi ? CLS_STRONG : CLS_WEAK;
        res_promo = any_hi;
      end
    end else begin
      res_cls = tap[CEN][1:0];
      if (tap[CEN][1:0] == CLS_WEAK && any_strong) begin
        res_cls   = CLS_STRONG;
        res_promo = 1'b1;
      end
    end
    if (wr_sel == BUF_DST) begin
      res_word  = (tap[CEN][1:0] == CLS_STRONG) ? PXL_BITS'(EDGE_VAL) : '0;
      res_promo = 1'b0;
    end else begin
      res_word = {{(PXL_BITS-2){1'b0}}, res_cls};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      pass_cnt    <= '0;
      promo_cnt   <= '0;
      rd_en       <= 1'b0;
      rd_x        <= '0;
      rd_y        <= '0;
      rd_sel      <= BUF_SRC;
      wr_en       <= 1'b0;
      wr_x        <= '0;
      wr_y        <= '0;
      wr_sel      <= BUF_SRC;
      wr_data_pxl <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      drn_cnt     <= '0;
    end else begin
      done  <= 1'b0;
      wr_en <= p_vld && !kill;
      if (p_vld && !kill) begin
        wr_x        <= p_x;
        wr_y        <= p_y;
        wr_data_pxl <= res_word;
        if (res_promo && promo_cnt != {PROMO_BITS{1'b1}}) promo_cnt <= promo_cnt + 1'b1;
      end

      if (kill) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        rd_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              hi_q      <= thresh_hi;
              lo_q      <= (thresh_lo > thresh_hi) ? thresh_hi : thresh_lo;
              pass_cnt  <= '0;
              promo_cnt <= '0;
              rd_en     <= 1'b1;
              rd_x      <= '0;
              rd_y      <= '0;
              rd_sel    <= BUF_SRC;
              wr_sel    <= BUF_SCR_A;
              busy      <= 1'b1;
              state     <= ST_SCAN;
            end
          end
          ST_SCAN, ST_OUT_SCAN: begin
            if (rd_x == X_LAST && rd_y == Y_LAST) begin
              rd_en   <= 1'b0;
              drn_cnt <= DRN_BITS'(RD_LAT);
              state   <= (state == ST_SCAN) ? ST_DRAIN : ST_OUT_DRAIN;
            end else if (rd_x == X_LAST) begin
              rd_x <= '0;
              rd_y <= rd_y + 1'b1;
            end else begin
              rd_x <= rd_x + 1'b1;
            end
          end
          ST_DRAIN: begin
            if (drn_cnt == '0) state <= ST_EVAL;
            else drn_cnt <= drn_cnt - 1'b1;
          end
          ST_EVAL: begin
            pass_cnt <= pass_nxt;
            rd_en    <= 1'b1;
            rd_x     <= '0;
            rd_y     <= '0;
            rd_sel   <= wr_sel;
            if (promo_cnt == '0 || pass_nxt == PASS_BITS'(MAX_PASSES)) begin
              converged <= (promo_cnt == '0);
              wr_sel    <= BUF_DST;
              state     <= ST_OUT_SCAN;
            end else begin
              wr_sel    <= (wr_sel == BUF_SCR_A) ? BUF_SCR_B : BUF_SCR_A;
              promo_cnt <= '0;
              state     <= ST_SCAN;
            end
          end
          ST_OUT_DRAIN: begin
            if (drn_cnt == '0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              drn_cnt <= drn_cnt - 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            rd_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
